pipe_flow_ctrl: RTL and testbench

- Central pipeline flow controller for the six-stage core (pc, if, id, ex, mem, wb).
- Merges stall requests from id/ex/mem and drives the 6-bit stall vector consumed by every pipeline register.
- Sequences exception/eret flushes and supplies the redirect PC.
- Runs a consecutive-stall watchdog that flags pipeline hangs.

---
 rtl/pipe_flow_ctrl.sv | 121 ++++++++++++
 tb/tb_pipe_flow_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_flow_ctrl.sv
// Pipeline flow controller: stall merge, exception/eret flush sequencing, stall watchdog.
// Optional performance counters are enabled by defining PIPE_FLOW_CTRL_PERF_EN.
module pipe_flow_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
  parameter int unsigned STALL_TIMEOUT = 1024,
  parameter int unsigned CNT_W         = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        stall_timeout_o
`ifdef PIPE_FLOW_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles_o,
  output logic [31:0] perf_flush_cnt_o,
  output logic [15:0] perf_eret_cnt_o
`endif
);

  localparam logic [31:0]      ERET_CODE  = 32'h0000_000e;
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(STALL_TIMEOUT);
  localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(STALL_TIMEOUT - 1);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t           r_state;
  logic             r_flush;
  logic [31:0]      r_new_pc;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_stall_timeout;

  logic             w_exc;
  logic             w_eret;
  logic [5:0]       w_stall;
  logic             w_stalling;

  assign w_exc  = |excepttype_i;
  assign w_eret = (excepttype_i == ERET_CODE);

  // An exception (or the flush cycle itself) overrides every stall request.
  always_comb begin
    w_stall = 6'b000000;
    if (rst && (r_state == ST_RUN) && !w_exc) begin
      if (stallreq_mem_i)     w_stall = 6'b011111;
      else if (stallreq_ex_i) w_stall = 6'b001111;
      else if (stallreq_id_i) w_stall = 6'b000111;
    end
  end

  assign w_stalling = |w_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_RUN;
      r_flush  <= 1'b0;
      r_new_pc <= 32'h0;
    end else if (r_state == ST_RUN) begin
      if (w_exc) begin
        r_state  <= ST_FLUSH;
        r_flush  <= 1'b1;
        r_new_pc <= w_eret ? cp0_epc_i : EXC_VECTOR;
      end
    end else begin
      // Exceptions arriving during the flush cycle are dropped.
      r_state <= ST_RUN;
      r_flush <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt     <= '0;
      r_stall_timeout <= 1'b0;
    end else if (!w_stalling) begin
      r_stall_cnt <= '0;
    end else if (r_stall_cnt != TIMEOUT_C) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
      if (r_stall_cnt == TIMEOUT_M1) r_stall_timeout <= 1'b1;
    end
  end

`ifdef PIPE_FLOW_CTRL_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;
  logic [15:0] r_perf_eret;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_stall <= 32'h0;
      r_perf_flush <= 32'h0;
      r_perf_eret  <= 16'h0;
    end else begin
      if (w_stalling) r_perf_stall <= r_perf_stall + 32'd1;
      if ((r_state == ST_RUN) && w_exc) begin
        r_perf_flush <= r_perf_flush + 32'd1;
        if (w_eret) r_perf_eret <= r_perf_eret + 16'd1;
      end
    end
  end

  assign perf_stall_cycles_o = r_perf_stall;
  assign perf_flush_cnt_o    = r_perf_flush;
  assign perf_eret_cnt_o     = r_perf_eret;
`endif

  assign stall_o         = w_stall;
  assign flush_o         = r_flush;
  assign new_pc_o        = r_new_pc;
  assign stall_timeout_o = r_stall_timeout;

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Directed bench for pipe_flow_ctrl: expected outputs queued per step, compared after settling.
module tb_pipe_flow_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_id_i = 1'b0;
  logic        stallreq_ex_i = 1'b0;
  logic        stallreq_mem_i = 1'b0;
  logic [31:0] excepttype_i = 32'h0;
  logic [31:0] cp0_epc_i = 32'h0;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        stall_timeout_o;
`ifdef PIPE_FLOW_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles_o;
  logic [31:0] perf_flush_cnt_o;
  logic [15:0] perf_eret_cnt_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [5:0]  st;
    logic        fl;
    logic [31:0] pc;
    logic        pc_chk;
    logic        tmo;
  } exp_t;

  exp_t sb[$];

  pipe_flow_ctrl #(
    .EXC_VECTOR   (32'h0000_0020),
    .STALL_TIMEOUT(8),
    .CNT_W        (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq_id_i  (stallreq_id_i),
    .stallreq_ex_i  (stallreq_ex_i),
    .stallreq_mem_i (stallreq_mem_i),
    .excepttype_i   (excepttype_i),
    .cp0_epc_i      (cp0_epc_i),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .new_pc_o       (new_pc_o),
    .stall_timeout_o(stall_timeout_o)
`ifdef PIPE_FLOW_CTRL_PERF_EN
    ,
    .perf_stall_cycles_o(perf_stall_cycles_o),
    .perf_flush_cnt_o   (perf_flush_cnt_o),
    .perf_eret_cnt_o    (perf_eret_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic id, input logic ex, input logic mem,
                       input logic [31:0] exc, input logic [31:0] epc);
    stallreq_id_i  = id;
    stallreq_ex_i  = ex;
    stallreq_mem_i = mem;
    excepttype_i   = exc;
    cp0_epc_i      = epc;
  endtask

  task automatic expect_out(input logic [5:0] st, input logic fl, input logic [31:0] pc,
                            input logic pc_chk, input logic tmo);
    exp_t e;
    e.st = st; e.fl = fl; e.pc = pc; e.pc_chk = pc_chk; e.tmo = tmo;
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    #1;
    n_checks++;
    assert (sb.size() != 0) else begin
      n_errors++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_stall"}, {26'h0, stall_o}, {26'h0, e.st});
      chk({tag, "_flush"}, {31'h0, flush_o}, {31'h0, e.fl});
      chk({tag, "_tmo"}, {31'h0, stall_timeout_o}, {31'h0, e.tmo});
      if (e.pc_chk) chk({tag, "_pc"}, new_pc_o, e.pc);
    end
  endtask

  // One clock cycle: drive after the falling edge, check settled outputs before the rising edge.
  task automatic cyc(input string tag, input logic id, input logic ex, input logic mem,
                     input logic [31:0] exc, input logic [31:0] epc,
                     input logic [5:0] st, input logic fl, input logic [31:0] pc,
                     input logic pc_chk, input logic tmo);
    @(negedge clk);
    drive(id, ex, mem, exc, epc);
    expect_out(st, fl, pc, pc_chk, tmo);
    check_out(tag);
  endtask

  initial begin
    // Reset held: stall forced low even with a request present.
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    #2;
    expect_out(6'b000000, 1'b0, 32'h0, 1'b1, 1'b0);
    check_out("reset");
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++)
      cyc("idle", 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 0, 0);

    for (int i = 0; i < 5; i++)
      cyc("ex_id", 1, 1, 0, 32'h0, 32'h0, 6'b001111, 0, 32'h0, 0, 0);
    cyc("ex_drop", 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 0, 0);
    cyc("mem_all", 1, 1, 1, 32'h0, 32'h0, 6'b011111, 0, 32'h0, 0, 0);
    cyc("mem_drop", 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 0, 0);

    cyc("exc_mem", 0, 0, 1, 32'h8, 32'h0, 6'b000000, 0, 32'h0, 0, 0);
    cyc("exc_flush", 0, 0, 1, 32'h0, 32'h0, 6'b000000, 1, 32'h20, 1, 0);
    cyc("exc_after", 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 0, 0);

    cyc("eret_req", 0, 0, 0, 32'he, 32'h1234, 6'b000000, 0, 32'h0, 0, 0);
    cyc("eret_flush", 0, 0, 1, 32'h8, 32'h0, 6'b000000, 1, 32'h1234, 1, 0);
    cyc("exc_dropped", 0, 0, 0, 32'h8, 32'h0, 6'b000000, 0, 32'h0, 0, 0);
    cyc("exc2_flush", 0, 0, 0, 32'h0, 32'h0, 6'b000000, 1, 32'h20, 1, 0);
    cyc("exc2_after", 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 0, 0);

    for (int i = 0; i < 7; i++)
      cyc("wd_hold7", 1, 0, 0, 32'h0, 32'h0, 6'b000111, 0, 32'h0, 0, 0);
    cyc("wd_gap", 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 0, 0);
    for (int i = 0; i < 8; i++)
      cyc("wd_hold8", 1, 0, 0, 32'h0, 32'h0, 6'b000111, 0, 32'h0, 0, 0);
    cyc("wd_set", 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 0, 1);
    cyc("wd_sticky", 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 0, 1);
    cyc("wd_honour", 0, 1, 0, 32'h0, 32'h0, 6'b001111, 0, 32'h0, 0, 1);
    cyc("wd_clear_cnt", 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 0, 1);

    // Asynchronous reset in the middle of a flush cycle.
    cyc("rst_exc", 0, 0, 0, 32'h8, 32'h0, 6'b000000, 0, 32'h0, 0, 1);
    @(negedge clk);
    drive(0, 0, 0, 32'h0, 32'h0);
    expect_out(6'b000000, 1'b1, 32'h20, 1'b1, 1'b1);
    check_out("rst_preflush");
    #1;
    rst = 1'b0;
    stallreq_mem_i = 1'b1;
    expect_out(6'b000000, 1'b0, 32'h0, 1'b1, 1'b0);
    check_out("rst_async");
    @(negedge clk);
    stallreq_mem_i = 1'b0;
    rst = 1'b1;
    cyc("post_rst_exc", 0, 0, 0, 32'h8, 32'h0, 6'b000000, 0, 32'h0, 0, 0);
    cyc("post_rst_flush", 0, 0, 0, 32'h0, 32'h0, 6'b000000, 1, 32'h20, 1, 0);
    cyc("post_rst_after", 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
